// File: rtl/apb2mem_pkg.sv
// apb2mem_pkg
//   Shared definitions for the APB4-to-native-memory bridge:
//   - state_e                : bridge FSM state encoding
//   - TIMEOUT_CYCLES_DEFAULT : default memory wait budget
//   - addr_in_range()        : inclusive unsigned window check
package apb2mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

    // The window bounds arrive as function arguments so a zero lower bound
    // does not turn the comparison into a constant expression.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] lo,
                                           input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/apb2mem.sv
// apb2mem
//   APB4 completer that forwards each transfer as a single native memory
//   request. Only one transfer is in flight at a time. Addresses outside
//   [ADDR_LO, ADDR_HI] are answered with PSLVERR and never reach memory.
//   A memory request that sees no mem_ready_i for TIMEOUT_CYCLES cycles is
//   withdrawn and answered with PSLVERR.
//
// Ports
//   clk_i, rst_n_i                 clock, synchronous active-low reset
//   apb_p*_i                       APB4 request (pprot is accepted, unused)
//   apb_pready_o/prdata_o/pslverr_o  APB4 response
//   mem_valid_o/addr_o/wdata_o/wstrb_o  memory request (wstrb 0 = read)
//   mem_rdata_i, mem_ready_i       memory response
//   dbg_state_o                    current FSM state
//
// Handshake: the memory request is held (valid, addr, wdata, wstrb all
// stable) from the cycle mem_valid_o rises until a cycle in which
// mem_ready_i is sampled high; that cycle completes the request.
module apb2mem
    import apb2mem_pkg::*;
#(
    parameter logic [31:0] ADDR_LO        = 32'h0000_0000,
    parameter logic [31:0] ADDR_HI        = 32'hFFFF_FFFF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] apb_paddr_i,
    input  logic [2:0]  apb_pprot_i,
    input  logic        apb_psel_i,
    input  logic        apb_penable_i,
    input  logic        apb_pwrite_i,
    input  logic [31:0] apb_pwdata_i,
    input  logic [3:0]  apb_pstrb_i,
    output logic        apb_pready_o,
    output logic [31:0] apb_prdata_o,
    output logic        apb_pslverr_o,
    output logic        mem_valid_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i,
    output state_e      dbg_state_o
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic setup_phase;
    logic access_phase;
    logic unused_pprot;

    assign setup_phase  = apb_psel_i && !apb_penable_i;
    assign access_phase = apb_psel_i && apb_penable_i;
    assign unused_pprot = ^apb_pprot_i;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (setup_phase) begin
                    addr_d  = apb_paddr_i;
                    wdata_d = apb_pwdata_i;
                    wstrb_d = apb_pwrite_i ? apb_pstrb_i : 4'b0000;
                    rdata_d = '0;
                    if (addr_in_range(apb_paddr_i, ADDR_LO, ADDR_HI)) begin
                        err_d   = 1'b0;
                        valid_d = 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        // Decode error: answer directly, memory never sees it.
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end

            ST_REQ: begin
                // Ready is checked first so it wins over a same-cycle timeout.
                if (mem_ready_i) begin
                    rdata_d = (wstrb_q == 4'b0000) ? mem_rdata_i : 32'h0;
                    err_d   = 1'b0;
                    valid_d = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RESP: begin
                // Deselect discards the result; an access phase consumes it.
                // A setup phase here is neither answered nor queued.
                if (!apb_psel_i || apb_penable_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign apb_pready_o  = (state_q == ST_RESP) && access_phase;
    assign apb_prdata_o  = apb_pready_o ? rdata_q : 32'h0;
    assign apb_pslverr_o = apb_pready_o && err_q;

    assign mem_valid_o = valid_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_wstrb_o = wstrb_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb2mem.sv
// tb_apb2mem
//   Two bridge instances: index 0 has a narrow window 0x1000_0000..0x1000_0FFF
//   and a 4-cycle memory timeout; index 1 uses the default window and timeout.
//   Each instance has its own APB and memory-side stimulus signals.
module tb_apb2mem;
    import apb2mem_pkg::*;

    logic        clk;
    logic        rst_n;

    logic        psel      [2];
    logic        penable   [2];
    logic        pwrite    [2];
    logic [31:0] paddr     [2];
    logic [31:0] pwdata    [2];
    logic [3:0]  pstrb     [2];
    logic        pready    [2];
    logic [31:0] prdata    [2];
    logic        pslverr   [2];
    logic        mem_valid [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [3:0]  mem_wstrb [2];
    logic [31:0] mem_rdata [2];
    logic        mem_ready [2];
    state_e      dbg_state [2];

    int n_tests;
    int n_fail;

    // Results of the most recent transfer.
    logic        r_done;
    int          r_waits;
    int          r_vcnt;
    logic [31:0] r_prdata;
    logic        r_slverr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_stable;

    apb2mem #(
        .ADDR_LO        (32'h1000_0000),
        .ADDR_HI        (32'h1000_0FFF),
        .TIMEOUT_CYCLES (4)
    ) dut_narrow (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .apb_paddr_i   (paddr[0]),
        .apb_pprot_i   (3'b000),
        .apb_psel_i    (psel[0]),
        .apb_penable_i (penable[0]),
        .apb_pwrite_i  (pwrite[0]),
        .apb_pwdata_i  (pwdata[0]),
        .apb_pstrb_i   (pstrb[0]),
        .apb_pready_o  (pready[0]),
        .apb_prdata_o  (prdata[0]),
        .apb_pslverr_o (pslverr[0]),
        .mem_valid_o   (mem_valid[0]),
        .mem_addr_o    (mem_addr[0]),
        .mem_wdata_o   (mem_wdata[0]),
        .mem_wstrb_o   (mem_wstrb[0]),
        .mem_rdata_i   (mem_rdata[0]),
        .mem_ready_i   (mem_ready[0]),
        .dbg_state_o   (dbg_state[0])
    );

    apb2mem dut_wide (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .apb_paddr_i   (paddr[1]),
        .apb_pprot_i   (3'b101),
        .apb_psel_i    (psel[1]),
        .apb_penable_i (penable[1]),
        .apb_pwrite_i  (pwrite[1]),
        .apb_pwdata_i  (pwdata[1]),
        .apb_pstrb_i   (pstrb[1]),
        .apb_pready_o  (pready[1]),
        .apb_prdata_o  (prdata[1]),
        .apb_pslverr_o (pslverr[1]),
        .mem_valid_o   (mem_valid[1]),
        .mem_addr_o    (mem_addr[1]),
        .mem_wdata_o   (mem_wdata[1]),
        .mem_wstrb_o   (mem_wstrb[1]),
        .mem_rdata_i   (mem_rdata[1]),
        .mem_ready_i   (mem_ready[1]),
        .dbg_state_o   (dbg_state[1])
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One APB transfer on instance idx. The memory model raises mem_ready in
    // the lat-th cycle that mem_valid is seen high (lat <= 0: never).
    task automatic xfer(input int idx, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input int lat, input logic [31:0] rd_val);
        int vcnt;
        int waits;
        logic done;
        vcnt = 0;
        waits = 0;
        done = 1'b0;
        r_stable = 1'b1;
        r_prdata = 'x;
        r_slverr = 1'bx;
        @(posedge clk); #1;
        psel[idx]    = 1'b1;
        penable[idx] = 1'b0;
        pwrite[idx]  = wr;
        paddr[idx]   = addr;
        pwdata[idx]  = wdata;
        pstrb[idx]   = strb;
        mem_ready[idx] = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(posedge clk); #1;
            penable[idx]   = 1'b1;
            mem_ready[idx] = 1'b0;
            mem_rdata[idx] = 32'h0;
            if (mem_valid[idx]) begin
                if (vcnt > 0 && (mem_addr[idx] !== r_addr || mem_wdata[idx] !== r_wdata ||
                                 mem_wstrb[idx] !== r_wstrb))
                    r_stable = 1'b0;
                r_addr  = mem_addr[idx];
                r_wdata = mem_wdata[idx];
                r_wstrb = mem_wstrb[idx];
                vcnt++;
                if (vcnt == lat) begin
                    mem_ready[idx] = 1'b1;
                    mem_rdata[idx] = rd_val;
                end
            end
            @(negedge clk);
            if (pready[idx]) begin
                done = 1'b1;
                r_prdata = prdata[idx];
                r_slverr = pslverr[idx];
            end else begin
                waits++;
            end
        end
        r_done  = done;
        r_waits = waits;
        r_vcnt  = vcnt;
        @(posedge clk); #1;
        psel[idx]      = 1'b0;
        penable[idx]   = 1'b0;
        mem_ready[idx] = 1'b0;
        mem_rdata[idx] = 32'h0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
            paddr[i] = 32'h0; pwdata[i] = 32'h0; pstrb[i] = 4'h0;
            mem_rdata[i] = 32'h0; mem_ready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        for (int i = 0; i < 2; i++) begin
            check("rst_valid",   32'(mem_valid[i]), 32'h0);
            check("rst_addr",    mem_addr[i], 32'h0);
            check("rst_wstrb",   32'(mem_wstrb[i]), 32'h0);
            check("rst_pready",  32'(pready[i]), 32'h0);
            check("rst_prdata",  prdata[i], 32'h0);
            check("rst_state",   32'(dbg_state[i]), 32'(ST_IDLE));
        end

        // Write with immediate memory ready: one wait state.
        xfer(0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'b0011, 1, 32'hFFFF_FFFF);
        check("wr_done",   32'(r_done), 32'h1);
        check("wr_wstrb",  32'(r_wstrb), 32'h3);
        check("wr_addr",   r_addr, 32'h1000_0010);
        check("wr_wdata",  r_wdata, 32'hDEAD_BEEF);
        check("wr_waits",  r_waits, 1);
        check("wr_vcnt",   r_vcnt, 1);
        check("wr_slverr", 32'(r_slverr), 32'h0);
        check("wr_prdata", r_prdata, 32'h0);

        // Out-of-window read: answered without touching memory.
        xfer(0, 1'b0, 32'h2000_0000, 32'h0, 4'h0, 1, 32'h5555_5555);
        check("oor_done",   32'(r_done), 32'h1);
        check("oor_vcnt",   r_vcnt, 0);
        check("oor_waits",  r_waits, 0);
        check("oor_slverr", 32'(r_slverr), 32'h1);
        check("oor_prdata", r_prdata, 32'h0);

        // Window edges.
        xfer(0, 1'b0, 32'h1000_0FFF, 32'h0, 4'h0, 1, 32'h0BAD_CAFE);
        check("hi_vcnt",   r_vcnt, 1);
        check("hi_prdata", r_prdata, 32'h0BAD_CAFE);
        check("hi_slverr", 32'(r_slverr), 32'h0);
        xfer(0, 1'b0, 32'h1000_1000, 32'h0, 4'h0, 1, 32'h1);
        check("hi1_vcnt",   r_vcnt, 0);
        check("hi1_slverr", 32'(r_slverr), 32'h1);
        xfer(0, 1'b0, 32'h0FFF_FFFF, 32'h0, 4'h0, 1, 32'h1);
        check("lo1_vcnt",   r_vcnt, 0);
        check("lo1_slverr", 32'(r_slverr), 32'h1);
        xfer(0, 1'b0, 32'h1000_0000, 32'h0, 4'h0, 1, 32'hA5A5_0001);
        check("lo_prdata", r_prdata, 32'hA5A5_0001);
        check("lo_slverr", 32'(r_slverr), 32'h0);

        // Timeout: memory never answers.
        xfer(0, 1'b0, 32'h1000_0100, 32'h0, 4'h0, 0, 32'h0);
        check("to_done",   32'(r_done), 32'h1);
        check("to_vcnt",   r_vcnt, 4);
        check("to_waits",  r_waits, 4);
        check("to_slverr", 32'(r_slverr), 32'h1);
        check("to_prdata", r_prdata, 32'h0);

        // Ready in the last allowed cycle beats the timeout.
        xfer(0, 1'b0, 32'h1000_0104, 32'h0, 4'h0, 4, 32'h7777_1234);
        check("tow_vcnt",   r_vcnt, 4);
        check("tow_slverr", 32'(r_slverr), 32'h0);
        check("tow_prdata", r_prdata, 32'h7777_1234);

        // Slow read; pstrb must be ignored on reads.
        xfer(1, 1'b0, 32'h1000_0020, 32'h0, 4'hF, 5, 32'h1234_5678);
        check("slow_done",   32'(r_done), 32'h1);
        check("slow_vcnt",   r_vcnt, 5);
        check("slow_waits",  r_waits, 5);
        check("slow_stable", 32'(r_stable), 32'h1);
        check("slow_wstrb",  32'(r_wstrb), 32'h0);
        check("slow_addr",   r_addr, 32'h1000_0020);
        check("slow_prdata", r_prdata, 32'h1234_5678);
        check("slow_slverr", 32'(r_slverr), 32'h0);

        // Back-to-back read / write / read.
        xfer(1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 1, 32'h0102_0304);
        check("b2b0_waits",  r_waits, 1);
        check("b2b0_prdata", r_prdata, 32'h0102_0304);
        check("b2b0_slverr", 32'(r_slverr), 32'h0);
        xfer(1, 1'b1, 32'hFFFF_FFFC, 32'hCAFE_BABE, 4'b1100, 1, 32'h9999_9999);
        check("b2b1_waits",  r_waits, 1);
        check("b2b1_wstrb",  32'(r_wstrb), 32'hC);
        check("b2b1_wdata",  r_wdata, 32'hCAFE_BABE);
        check("b2b1_prdata", r_prdata, 32'h0);
        xfer(1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 1, 32'hF0E1_D2C3);
        check("b2b2_waits",  r_waits, 1);
        check("b2b2_prdata", r_prdata, 32'hF0E1_D2C3);
        check("b2b2_slverr", 32'(r_slverr), 32'h0);

        // Reset pulse while a request is outstanding.
        @(posedge clk); #1;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0;
        paddr[1] = 32'h1000_0040; mem_ready[1] = 1'b0;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(negedge clk);
        check("rq_valid", 32'(mem_valid[1]), 32'h1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rq_rst_valid",  32'(mem_valid[1]), 32'h0);
        check("rq_rst_state",  32'(dbg_state[1]), 32'(ST_IDLE));
        check("rq_rst_pready", 32'(pready[1]), 32'h0);
        check("rq_rst_addr",   mem_addr[1], 32'h0);
        @(posedge clk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        xfer(1, 1'b0, 32'h1000_0044, 32'h0, 4'h0, 2, 32'hCAFE_F00D);
        check("post_done",   32'(r_done), 32'h1);
        check("post_waits",  r_waits, 2);
        check("post_prdata", r_prdata, 32'hCAFE_F00D);
        check("post_slverr", 32'(r_slverr), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb2mem.md
APB2MEM -- requirements
Module: apb2mem

Interface
REQ-001 Parameter ADDR_LO, 32'h0000_0000, lowest accepted byte address (inclusive).
REQ-002 Parameter ADDR_HI, 32'hFFFF_FFFF, highest accepted byte address (inclusive).
REQ-003 Parameter TIMEOUT_CYCLES, 255, mem wait cycles before abort; legal range 1..65535.
REQ-004 clk_i  input  1  single clock; all logic rising-edge.
REQ-005 rst_n_i  input  1  reset, synchronous, active-low.
REQ-006 apb_paddr_i  input  32  APB4 completer address.
REQ-007 apb_pprot_i  input  3  protection; accepted, ignored.
REQ-008 apb_psel_i / apb_penable_i / apb_pwrite_i  input  1 each  APB4 select, enable, write.
REQ-009 apb_pwdata_i  input  32; apb_pstrb_i  input  4  write data and byte strobes.
REQ-010 apb_pready_o  output  1; apb_prdata_o  output  32; apb_pslverr_o  output  1  APB4 response.
REQ-011 mem_valid_o  output  1; mem_addr_o  output  32; mem_wdata_o  output  32; mem_wstrb_o  output  4  native mem request (wstrb 0 = read).
REQ-012 mem_rdata_i  input  32; mem_ready_i  input  1  native mem response.

Function
REQ-013 FSM states IDLE, REQ, RESP; one transfer in flight.
REQ-014 IDLE: setup phase (psel=1, penable=0) captures paddr, pwdata, wstrb (pstrb if pwrite, else 4'b0000); in range -> REQ, out of range -> RESP with err flag set, no mem request.
REQ-015 Range check ADDR_LO <= paddr <= ADDR_HI, unsigned 32-bit compare.
REQ-016 REQ: mem_valid_o=1 registered; addr/wdata/wstrb held stable until mem_ready_i sampled high.
REQ-017 REQ with mem_ready_i=1: capture mem_rdata_i (reads only; writes capture 0), clear err, mem_valid_o=0 next cycle, -> RESP.
REQ-018 REQ timeout counter starts at 0 on entry; counter == TIMEOUT_CYCLES-1 with mem_ready_i=0 -> mem_valid_o=0, err set, prdata 0, -> RESP; ready and timeout same cycle: ready wins.
REQ-019 RESP: apb_pready_o=1 combinationally only when psel=1 and penable=1; apb_prdata_o=captured data, apb_pslverr_o=err flag; -> IDLE after that cycle.
REQ-020 Outside RESP-with-access: apb_pready_o=0, apb_pslverr_o=0, apb_prdata_o=0.
REQ-021 Minimum latency: setup T0, mem_valid_o T1, mem_ready_i at T1 -> pready T2 (one APB wait state).
REQ-022 psel dropping during REQ: mem transaction still completes (or times out); RESP then waits for next access phase, or returns to IDLE on any cycle with psel=0 in RESP, result discarded.
REQ-023 Setup phases arriving in REQ/RESP are ignored; no request queued.

Reset
REQ-024 rst_n_i=0 at a rising edge: state IDLE, mem_valid_o=0, mem_addr_o/mem_wdata_o=0, mem_wstrb_o=0, captured data 0, err 0, counter 0.
REQ-025 Reset mid-REQ drops mem_valid_o at the same edge; no APB response issued for the aborted transfer.

Structure
REQ-026 State enum typedef and default TIMEOUT constant live in shared package apb2mem_pkg.
REQ-027 Single flat module; no sub-module; counter width $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-028 Write 0x1000_0010 data 0xDEAD_BEEF pstrb 4'b0011, mem_ready at T1 -> mem_wstrb_o 0011, pready at T2, pslverr 0.
REQ-029 Read 0x1000_0020, mem_ready after 5 cycles with rdata 0x1234_5678 -> prdata 0x1234_5678, pslverr 0, mem_valid held 5 cycles.
REQ-030 ADDR_LO=0x1000_0000, ADDR_HI=0x1000_0FFF, read 0x2000_0000 -> no mem_valid_o, pready with pslverr 1, prdata 0.
REQ-031 TIMEOUT_CYCLES=4, mem_ready never -> mem_valid_o exactly 4 cycles, then pready, pslverr 1.
REQ-032 rst_n_i low for one cycle in REQ -> mem_valid_o 0 next cycle, state IDLE, next transfer completes normally.
REQ-033 Back-to-back read/write/read with mem_ready tied 1 -> each completes in one wait state, correct data, no pslverr.
